// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 VGA timing constants, axis phase type, sync/blank pipe word
package vga_timing_pkg;

  localparam int COORD_W = 11;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } vga_phase_t;

  // Everything that must be delayed to line up with the renderer colour.
  typedef struct packed {
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
    logic       hs_n;
    logic       vs_n;
    logic       blank_n;
  } vga_ctl_t;

  localparam vga_ctl_t CTL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, default: '0};

  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    return {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output vga_phase_t         phase,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] LAST     = COORD_W'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [COORD_W-1:0] FRONT_AT = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_AT  = COORD_W'(ACTIVE + FP);
  localparam logic [COORD_W-1:0] BACK_AT  = COORD_W'(ACTIVE + FP + SYNC);

  logic [COORD_W-1:0] count_next;
  vga_phase_t         phase_next;

  assign wrap = (count == LAST);

  // Phase moves on the boundary the counter is about to cross, so it stays aligned with count.
  always_comb begin
    count_next = wrap ? '0 : count + 1'b1;
    phase_next = phase;
    case (phase)
      PH_ACTIVE: if (count_next == FRONT_AT) phase_next = PH_FRONT;
      PH_FRONT:  if (count_next == SYNC_AT)  phase_next = PH_SYNC;
      PH_SYNC:   if (count_next == BACK_AT)  phase_next = PH_BACK;
      PH_BACK:   if (wrap)                   phase_next = PH_ACTIVE;
      default:   phase_next = PH_ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      phase <= PH_ACTIVE;
    end else if (en) begin
      count <= count_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing source with renderer-latency-matched sync/blank and colour output
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (adds test_mode input).
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int PIPE_DLY = 1
) (
  input  logic                               CLOCK_50,
  input  logic                               reset,
  output logic [vga_timing_pkg::COORD_W-1:0] posX,
  output logic [vga_timing_pkg::COORD_W-1:0] posY,
  output logic                               pix_tick,
  output logic                               frame_start,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                               test_mode,
`endif
  input  logic [7:0]                         in_r,
  input  logic [7:0]                         in_g,
  input  logic [7:0]                         in_b,
  output logic [7:0]                         VGA_R,
  output logic [7:0]                         VGA_G,
  output logic [7:0]                         VGA_B,
  output logic                               VGA_HS,
  output logic                               VGA_VS,
  output logic                               VGA_BLANK_N,
  output logic                               VGA_SYNC_N,
  output logic                               VGA_CLK
);

  import vga_timing_pkg::*;

  logic       tick_phase;
  logic       at_origin;
  logic       h_wrap;
  logic       v_wrap;
  vga_phase_t h_phase;
  vga_phase_t v_phase;
  vga_ctl_t   ctl_raw;
  vga_ctl_t   ctl_dly;
  logic [23:0] rgb_next;

  // pix_tick is the registered copy of the phase, so the first tick lands two cycles after reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick_phase <= 1'b0;
      pix_tick   <= 1'b0;
    end else begin
      tick_phase <= ~tick_phase;
      pix_tick   <= tick_phase;
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk   (CLOCK_50),
    .reset (reset),
    .en    (pix_tick),
    .count (posX),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk   (CLOCK_50),
    .reset (reset),
    .en    (pix_tick & h_wrap),
    .count (posY),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  always_comb begin
    ctl_raw         = CTL_IDLE;
    ctl_raw.hs_n    = (h_phase != PH_SYNC);
    ctl_raw.vs_n    = (v_phase != PH_SYNC);
    ctl_raw.blank_n = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
`ifdef VGA_TEST_PATTERN_EN
    ctl_raw.bar     = posX[9:7];
`endif
  end

  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign ctl_dly = ctl_raw;
    end else begin : g_dly
      vga_ctl_t pipe [PIPE_DLY];

      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DLY; i++) pipe[i] <= CTL_IDLE;
        end else if (pix_tick) begin
          pipe[0] <= ctl_raw;
          for (int i = 1; i < PIPE_DLY; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign ctl_dly = pipe[PIPE_DLY-1];
    end
  endgenerate

  always_comb begin
    rgb_next = {in_r, in_g, in_b};
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) rgb_next = bar_colour(ctl_dly.bar);
`endif
    if (!ctl_dly.blank_n) rgb_next = '0;
  end

  // Sync, blank and colour share one output register so they change on the same pixel.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      VGA_HS                <= 1'b1;
      VGA_VS                <= 1'b1;
      VGA_BLANK_N           <= 1'b0;
      {VGA_R, VGA_G, VGA_B} <= '0;
      at_origin             <= 1'b1;
    end else if (pix_tick) begin
      VGA_HS                <= ctl_dly.hs_n;
      VGA_VS                <= ctl_dly.vs_n;
      VGA_BLANK_N           <= ctl_dly.blank_n;
      {VGA_R, VGA_G, VGA_B} <= rgb_next;
      at_origin             <= h_wrap & v_wrap;
    end
  end

  assign frame_start = pix_tick & at_origin;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = tick_phase;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of VGA timing, sync delay, blanking and reset restart
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst_full = 1'b1;
  logic       rst_small = 1'b1;
  logic [7:0] in_r, in_g, in_b;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif

  logic [10:0] f_posx, f_posy;
  logic        f_tick, f_fs, f_hs, f_vs, f_bn, f_sn, f_clk;
  logic [7:0]  f_r, f_g, f_b;

  logic [10:0] s_posx [4];
  logic [10:0] s_posy [4];
  logic        s_tick [4];
  logic        s_fs   [4];
  logic        s_hs   [4];
  logic        s_vs   [4];
  logic        s_bn   [4];
  logic        s_sn   [4];
  logic        s_clk  [4];
  logic [7:0]  s_r    [4];
  logic [7:0]  s_g    [4];
  logic [7:0]  s_b    [4];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(.PIPE_DLY(1)) u_full (
    .CLOCK_50    (clk),
    .reset       (rst_full),
    .posX        (f_posx),
    .posY        (f_posy),
    .pix_tick    (f_tick),
    .frame_start (f_fs),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .in_r        (in_r),
    .in_g        (in_g),
    .in_b        (in_b),
    .VGA_R       (f_r),
    .VGA_G       (f_g),
    .VGA_B       (f_b),
    .VGA_HS      (f_hs),
    .VGA_VS      (f_vs),
    .VGA_BLANK_N (f_bn),
    .VGA_SYNC_N  (f_sn),
    .VGA_CLK     (f_clk)
  );

  // Shrunken timing (25 x 10 total) so whole frames fit; one instance per PIPE_DLY value.
  for (genvar g = 0; g < 4; g++) begin : g_small
    vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
      .PIPE_DLY(g)
    ) u_dut (
      .CLOCK_50    (clk),
      .reset       (rst_small),
      .posX        (s_posx[g]),
      .posY        (s_posy[g]),
      .pix_tick    (s_tick[g]),
      .frame_start (s_fs[g]),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode   (1'b0),
`endif
      .in_r        (in_r),
      .in_g        (in_g),
      .in_b        (in_b),
      .VGA_R       (s_r[g]),
      .VGA_G       (s_g[g]),
      .VGA_B       (s_b[g]),
      .VGA_HS      (s_hs[g]),
      .VGA_VS      (s_vs[g]),
      .VGA_BLANK_N (s_bn[g]),
      .VGA_SYNC_N  (s_sn[g]),
      .VGA_CLK     (s_clk[g])
    );
  end

  task automatic reset_full();
    rst_full = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_full = 1'b0;
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if (f_tick !== 1'b0 || f_posx !== 11'd0 || f_posy !== 11'd0 || f_fs !== 1'b0) begin
      bad++;
      $display("FAIL reset_counters tick=%b x=%0d y=%0d fs=%b want 0/0/0/0", f_tick, f_posx, f_posy, f_fs);
    end
    total++;
    if (f_hs !== 1'b1 || f_vs !== 1'b1 || f_bn !== 1'b0 || f_r !== 8'h00 || f_sn !== 1'b0 || f_clk !== 1'b0) begin
      bad++;
      $display("FAIL reset_pins hs=%b vs=%b bn=%b r=%h sn=%b clk=%b want 1/1/0/00/0/0", f_hs, f_vs, f_bn, f_r, f_sn, f_clk);
    end
    rst_full = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if (f_tick !== (c % 2 == 0) || f_posx !== 11'((c - 1) / 2) || f_fs !== (c == 2)) begin
        bad++;
        $display("FAIL release_seq c=%0d tick=%b x=%0d fs=%b want %b/%0d/%b", c, f_tick, f_posx, f_fs, (c % 2 == 0), (c - 1) / 2, (c == 2));
      end
      total++;
      if (f_hs !== 1'b1 || f_vs !== 1'b1 || f_bn !== 1'b0 || f_clk !== (c % 2 == 1)) begin
        bad++;
        $display("FAIL release_pins c=%0d hs=%b vs=%b bn=%b clk=%b want 1/1/0/%b", c, f_hs, f_vs, f_bn, f_clk, (c % 2 == 1));
      end
    end
  endtask

  task automatic test_line();
    int k, cyc, low_cnt, first_low, s, t800;
    logic pend, exp_low;
    k = 0; cyc = 0; low_cnt = 0; first_low = -1; pend = 1'b0; t800 = -1;
    reset_full();
    while (k < 802 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      total++;
      if (f_tick !== (cyc % 2 == 0)) begin
        bad++;
        $display("FAIL line_tick cyc=%0d got=%b want=%b", cyc, f_tick, (cyc % 2 == 0));
      end
      if (f_tick) begin
        total++;
        if (f_posx !== 11'(k % 800) || f_posy !== 11'(k / 800)) begin
          bad++;
          $display("FAIL line_pos tick=%0d x=%0d y=%0d want %0d/%0d", k, f_posx, f_posy, k % 800, k / 800);
        end
        if (k == 800) t800 = cyc;
        pend = 1'b1;
        k++;
      end else if (pend) begin
        s = k - 2;
        exp_low = (s >= 0) && (s % 800 >= 656) && (s % 800 <= 751);
        total++;
        if (f_hs !== !exp_low) begin
          bad++;
          $display("FAIL line_hs after tick=%0d got=%b want=%b", k - 1, f_hs, !exp_low);
        end
        if (!f_hs && k - 1 < 800) begin
          low_cnt++;
          if (first_low < 0) first_low = k - 1;
        end
        pend = 1'b0;
      end
    end
    total++;
    if (k < 802) begin bad++; $display("FAIL line_timeout ticks=%0d want 802", k); end
    total++;
    if (low_cnt != 96) begin bad++; $display("FAIL line_hs_width got=%0d want 96", low_cnt); end
    total++;
    if (first_low != 657) begin bad++; $display("FAIL line_hs_start posX=%0d want 657", first_low); end
    total++;
    if (t800 != 1602) begin bad++; $display("FAIL line_period cycle=%0d want 1602", t800); end
  endtask

  task automatic test_frame_small();
    int k, cyc, s, x, y, fs0, fs1;
    int bn_cnt [4];
    int vs_cnt [4];
    logic pend, ok, ehs, evs, ebn;
    k = 0; cyc = 0; pend = 1'b0; fs0 = -1; fs1 = -1;
    for (int d = 0; d < 4; d++) begin bn_cnt[d] = 0; vs_cnt[d] = 0; end
    rst_small = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_small = 1'b0;
    while (k < 254 && cyc < 700) begin
      @(negedge clk);
      cyc++;
      if (s_tick[0]) begin
        for (int d = 0; d < 4; d++) begin
          total++;
          if (s_tick[d] !== 1'b1 || s_posx[d] !== 11'(k % 25) || s_posy[d] !== 11'((k / 25) % 10) || s_fs[d] !== (k % 250 == 0)) begin
            bad++;
            $display("FAIL frame_pos d=%0d tick=%0d x=%0d y=%0d fs=%b want %0d/%0d/%b", d, k, s_posx[d], s_posy[d], s_fs[d], k % 25, (k / 25) % 10, (k % 250 == 0));
          end
        end
        if (s_fs[0] && fs0 < 0) fs0 = cyc;
        else if (s_fs[0] && fs1 < 0) fs1 = cyc;
        pend = 1'b1;
        k++;
      end else if (pend) begin
        for (int d = 0; d < 4; d++) begin
          s = k - 1 - d;
          ok = (s >= 0);
          x = ok ? s % 25 : 0;
          y = ok ? (s / 25) % 10 : 0;
          ehs = !(ok && x >= 18 && x < 22);
          evs = !(ok && y >= 7 && y < 9);
          ebn = ok && x < 16 && y < 6;
          total++;
          if (s_hs[d] !== ehs || s_vs[d] !== evs || s_bn[d] !== ebn) begin
            bad++;
            $display("FAIL frame_sync d=%0d tick=%0d hs=%b vs=%b bn=%b want %b/%b/%b", d, k - 1, s_hs[d], s_vs[d], s_bn[d], ehs, evs, ebn);
          end
          total++;
          if (s_r[d] !== (ebn ? 8'hAA : 8'h00) || s_g[d] !== (ebn ? 8'h55 : 8'h00) || s_b[d] !== (ebn ? 8'h0F : 8'h00)) begin
            bad++;
            $display("FAIL frame_rgb d=%0d tick=%0d rgb=%h%h%h bn_exp=%b", d, k - 1, s_r[d], s_g[d], s_b[d], ebn);
          end
          if (k - 1 >= d && k - 1 < 250 + d) begin
            if (s_bn[d]) bn_cnt[d]++;
            if (!s_vs[d]) vs_cnt[d]++;
          end
        end
        pend = 1'b0;
      end
    end
    total++;
    if (k < 254) begin bad++; $display("FAIL frame_timeout ticks=%0d want 254", k); end
    for (int d = 0; d < 4; d++) begin
      total++;
      if (bn_cnt[d] != 96 || vs_cnt[d] != 50) begin
        bad++;
        $display("FAIL frame_counts d=%0d blank_hi=%0d vs_lo=%0d want 96/50", d, bn_cnt[d], vs_cnt[d]);
      end
    end
    total++;
    if (fs1 - fs0 != 500) begin bad++; $display("FAIL frame_start_period got=%0d want 500", fs1 - fs0); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic found;
    cyc = 0; found = 1'b0;
    reset_full();
    while (!found && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (f_tick && f_posx == 11'd400) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL mid_timeout posX=%0d want 400", f_posx); end
    total++;
    if (f_bn !== 1'b1 || f_r !== 8'hAA) begin bad++; $display("FAIL mid_active bn=%b r=%h want 1/aa", f_bn, f_r); end
    rst_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (f_posx !== 11'd0 || f_posy !== 11'd0 || f_tick !== 1'b0 || f_fs !== 1'b0 ||
          f_hs !== 1'b1 || f_vs !== 1'b1 || f_bn !== 1'b0 || f_r !== 8'h00) begin
        bad++;
        $display("FAIL mid_hold x=%0d y=%0d tick=%b hs=%b vs=%b bn=%b r=%h", f_posx, f_posy, f_tick, f_hs, f_vs, f_bn, f_r);
      end
    end
    rst_full = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if (f_tick !== (c == 2) || f_posx !== 11'(c / 3) || f_posy !== 11'd0 || f_bn !== 1'b0) begin
        bad++;
        $display("FAIL mid_restart c=%0d tick=%b x=%0d y=%0d bn=%b want %b/%0d/0/0", c, f_tick, f_posx, f_posy, f_bn, (c == 2), c / 3);
      end
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int k, cyc, s, bar;
    logic pend;
    logic [7:0] er, eg, eb;
    k = 0; cyc = 0; pend = 1'b0;
    test_mode = 1'b1;
    reset_full();
    while (k < 645 && cyc < 1400) begin
      @(negedge clk);
      cyc++;
      if (f_tick) begin
        pend = 1'b1;
        k++;
      end else if (pend) begin
        s = k - 2;
        bar = (s >= 0 && s < 640) ? s / 128 : 0;
        er = (s >= 0 && s < 640 && (bar & 4) != 0) ? 8'hFF : 8'h00;
        eg = (s >= 0 && s < 640 && (bar & 2) != 0) ? 8'hFF : 8'h00;
        eb = (s >= 0 && s < 640 && (bar & 1) != 0) ? 8'hFF : 8'h00;
        total++;
        if (f_r !== er || f_g !== eg || f_b !== eb) begin
          bad++;
          $display("FAIL pattern tick=%0d rgb=%h%h%h want %h%h%h", k - 1, f_r, f_g, f_b, er, eg, eb);
        end
        pend = 1'b0;
      end
    end
    total++;
    if (k < 645) begin bad++; $display("FAIL pattern_timeout ticks=%0d want 645", k); end
    test_mode = 1'b0;
  endtask
`endif

  initial begin
    in_r = 8'hAA;
    in_g = 8'h55;
    in_b = 8'h0F;
    test_reset();
    test_line();
    test_frame_small();
    test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
